rf_tx_sequencer: RTL and testbench

//  Byte-to-symbol transmit controller for the NCO-driven RF output. Buffers bytes from the

---
 rtl/rf_pkg.sv | 34 +++
 rtl/rf_tx_fifo.sv | 63 ++++++
 rtl/rf_tx_sequencer.sv | 157 +++++++++++++++
 tb/tb_rf_tx_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the RF transmit sequencer: FSM states, default NCO words
// and the symbol keying helper.
package rf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_START    = 3'd2,
      ST_DATA     = 3'd3,
      ST_STOP     = 3'd4
   } tx_state_e;

   localparam logic [15:0] MARK_CW_DEF  = 16'h4000;
   localparam logic [15:0] SPACE_CW_DEF = 16'h3C00;
   localparam logic [15:0] BPSK_PI      = 16'h8000;

   // Returns {control_word, phase_word} for one symbol.
   // FSK moves the frequency; BPSK keeps the carrier and flips the phase by pi.
   function automatic logic [31:0] key_words(input logic mark, input logic bpsk,
                                             input logic [15:0] mark_cw,
                                             input logic [15:0] space_cw);
      logic [15:0] cw;
      logic [15:0] pw;
      cw = mark_cw;
      pw = 16'h0000;
      if (bpsk) begin
         pw = mark ? 16'h0000 : BPSK_PI;
      end else begin
         cw = mark ? mark_cw : space_cw;
      end
      return {cw, pw};
   endfunction

endpackage

// File: rtl/rf_tx_fifo.sv
// Small synchronous byte FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module rf_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr];

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= ptr_next(wr_ptr);
         end
         if (rd_en) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rf_tx_sequencer.sv
// Frames buffered bytes (preamble, start, 8 data LSB-first, stop) and drives the NCO
// control/phase words per symbol for FSK or BPSK keying.
module rf_tx_sequencer
   import rf_pkg::*;
#(
   parameter int          SYM_CNT    = 3333,
   parameter int          SCW        = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1,
   parameter logic [15:0] MARK_CW    = MARK_CW_DEF,
   parameter logic [15:0] SPACE_CW   = SPACE_CW_DEF,
   parameter int          PRE_SYMS   = 8,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        mode,
   input  logic [7:0]  in_dat,
   input  logic        in_stb,
   output logic [15:0] control_word,
   output logic [15:0] phase_word,
   output logic        tx_en,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);

   localparam int PCW = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   tx_state_e      state;
   logic [SCW-1:0] sym_cnt;
   logic [2:0]     bit_idx;
   logic [PCW-1:0] pre_cnt;
   logic [7:0]     shreg;
   logic           mode_q;

   logic [7:0]     fifo_dout;
   logic           fifo_empty;
   logic [FCW-1:0] fifo_count;
   logic           sym_end;
   logic           pop;

   rf_tx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_stb),
      .din   (in_dat),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign sym_end = (sym_cnt == SCW'(SYM_CNT - 1));
   // A new byte is taken either on leaving IDLE or at the end of STOP for back-to-back frames.
   assign pop  = en && !fifo_empty &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && sym_end));
   assign busy = (state != ST_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         sym_cnt      <= '0;
         bit_idx      <= '0;
         pre_cnt      <= '0;
         shreg        <= '0;
         mode_q       <= 1'b0;
         control_word <= MARK_CW;
         phase_word   <= 16'h0000;
         tx_en        <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         overflow <= in_stb && fifo_full && !pop;
         if (state != ST_IDLE) begin
            sym_cnt <= sym_end ? '0 : sym_cnt + 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  shreg   <= fifo_dout;
                  mode_q  <= mode;
                  sym_cnt <= '0;
                  bit_idx <= '0;
                  pre_cnt <= '0;
                  tx_en   <= 1'b1;
                  if (PRE_SYMS == 0) begin
                     state                      <= ST_START;
                     {control_word, phase_word} <= key_words(1'b0, mode, MARK_CW, SPACE_CW);
                  end else begin
                     state                      <= ST_PREAMBLE;
                     {control_word, phase_word} <= key_words(1'b1, mode, MARK_CW, SPACE_CW);
                  end
               end else begin
                  control_word <= MARK_CW;
                  phase_word   <= 16'h0000;
                  tx_en        <= 1'b0;
               end
            end
            ST_PREAMBLE: begin
               if (sym_end) begin
                  if (pre_cnt == PCW'(PRE_SYMS - 1)) begin
                     state                      <= ST_START;
                     {control_word, phase_word} <= key_words(1'b0, mode_q, MARK_CW, SPACE_CW);
                  end else begin
                     // Next symbol index is pre_cnt+1; it is a mark when even, i.e. pre_cnt odd.
                     pre_cnt                    <= pre_cnt + 1'b1;
                     {control_word, phase_word} <= key_words(pre_cnt[0], mode_q, MARK_CW, SPACE_CW);
                  end
               end
            end
            ST_START: begin
               if (sym_end) begin
                  state                      <= ST_DATA;
                  bit_idx                    <= '0;
                  {control_word, phase_word} <= key_words(shreg[0], mode_q, MARK_CW, SPACE_CW);
               end
            end
            ST_DATA: begin
               if (sym_end) begin
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state                      <= ST_STOP;
                     {control_word, phase_word} <= key_words(1'b1, mode_q, MARK_CW, SPACE_CW);
                  end else begin
                     bit_idx                    <= bit_idx + 1'b1;
                     {control_word, phase_word} <= key_words(shreg[1], mode_q, MARK_CW, SPACE_CW);
                  end
               end
            end
            ST_STOP: begin
               if (sym_end) begin
                  if (pop) begin
                     shreg                      <= fifo_dout;
                     bit_idx                    <= '0;
                     state                      <= ST_START;
                     {control_word, phase_word} <= key_words(1'b0, mode_q, MARK_CW, SPACE_CW);
                  end else begin
                     state        <= ST_IDLE;
                     tx_en        <= 1'b0;
                     control_word <= MARK_CW;
                     phase_word   <= 16'h0000;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               tx_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rf_tx_sequencer.sv
// Directed bench for rf_tx_sequencer with SYM_CNT=4, PRE_SYMS=8, FIFO_DEPTH=4.
module tb_rf_tx_sequencer;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        mode;
   logic [7:0]  in_dat;
   logic        in_stb;
   logic [15:0] control_word;
   logic [15:0] phase_word;
   logic        tx_en;
   logic        busy;
   logic        fifo_full;
   logic        overflow;

   int   tests_run;
   int   tests_failed;
   logic exp_q[$];

   rf_tx_sequencer #(
      .SYM_CNT    (4),
      .PRE_SYMS   (8),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .in_dat       (in_dat),
      .in_stb       (in_stb),
      .control_word (control_word),
      .phase_word   (phase_word),
      .tx_en        (tx_en),
      .busy         (busy),
      .fifo_full    (fifo_full),
      .overflow     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      in_dat = b;
      in_stb = 1'b1;
      @(negedge clk);
      in_stb = 1'b0;
   endtask

   task automatic wait_rise(output int n);
      n = 0;
      while (tx_en !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tx_rise_timeout", {31'd0, tx_en}, 32'd1);
   endtask

   task automatic push_pre();
      for (int k = 0; k < 8; k++) exp_q.push_back((k % 2) == 0);
   endtask

   task automatic push_byte(input logic [7:0] b);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(1'b1);
   endtask

   // Walks the frame from cycle c0 after tx_en rose; checks mid-symbol words and tx_en length.
   task automatic check_frame(input string name, input int c0, input int drop_at, input logic bpsk);
      int   n;
      int   hi;
      logic m;
      logic [15:0] ecw;
      logic [15:0] epw;
      n  = exp_q.size();
      hi = 0;
      for (int c = c0; c < n * 4; c++) begin
         if (c == drop_at) en = 1'b0;
         if (tx_en === 1'b1) hi++;
         if ((c % 4) == 1) begin
            m   = exp_q[c / 4];
            ecw = (bpsk || m) ? 16'h4000 : 16'h3C00;
            epw = (bpsk && !m) ? 16'h8000 : 16'h0000;
            chk($sformatf("%s_cw_sym%0d", name, c / 4), {16'd0, control_word}, {16'd0, ecw});
            chk($sformatf("%s_pw_sym%0d", name, c / 4), {16'd0, phase_word}, {16'd0, epw});
         end
         @(negedge clk);
      end
      chk({name, "_tx_fall"}, {31'd0, tx_en}, 32'd0);
      chk({name, "_tx_len"}, hi, n * 4 - c0);
      chk({name, "_cw_idle"}, {16'd0, control_word}, 32'h4000);
      chk({name, "_pw_idle"}, {16'd0, phase_word}, 32'h0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      int hi;
      tests_run    = 0;
      tests_failed = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      mode   = 1'b0;
      in_dat = 8'h00;
      in_stb = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset values
      chk("rst_cw", {16'd0, control_word}, 32'h4000);
      chk("rst_pw", {16'd0, phase_word}, 32'h0);
      chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);

      // single 0xA5, FSK
      en = 1'b1;
      send_byte(8'hA5);
      wait_rise(n);
      chk("fsk_rise_latency", n, 1);
      push_pre();
      push_byte(8'hA5);
      check_frame("fsk_a5", 0, -1, 1'b0);
      chk("fsk_a5_busy_end", {31'd0, busy}, 32'd0);

      // single 0xA5, BPSK; mode toggled back mid-frame must be ignored
      mode = 1'b1;
      send_byte(8'hA5);
      wait_rise(n);
      chk("bpsk_rise_latency", n, 1);
      mode = 1'b0;
      push_pre();
      push_byte(8'hA5);
      check_frame("bpsk_a5", 0, -1, 1'b1);

      // two bytes on consecutive cycles -> one preamble, back-to-back frames
      @(negedge clk);
      in_dat = 8'h3C;
      in_stb = 1'b1;
      @(negedge clk);
      in_dat = 8'hC3;
      @(negedge clk);
      in_stb = 1'b0;
      wait_rise(n);
      chk("two_rise_latency", n, 0);
      push_pre();
      push_byte(8'h3C);
      push_byte(8'hC3);
      check_frame("two", 0, -1, 1'b0);

      // overflow: B0 popped, B1..B4 stored, B5 dropped
      send_byte(8'h11);
      wait_rise(n);
      for (int i = 0; i < 5; i++) begin
         in_dat = 8'h22 + 8'(i * 17);
         in_stb = 1'b1;
         @(negedge clk);
         if (i == 3) begin
            chk("ovf_full_at4", {31'd0, fifo_full}, 32'd1);
            chk("ovf_none_at4", {31'd0, overflow}, 32'd0);
         end
      end
      chk("ovf_pulse", {31'd0, overflow}, 32'd1);
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
      in_stb = 1'b0;
      @(negedge clk);
      chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
      push_pre();
      push_byte(8'h11);
      push_byte(8'h22);
      push_byte(8'h33);
      push_byte(8'h44);
      push_byte(8'h55);
      check_frame("ovf", 6, -1, 1'b0);
      chk("ovf_busy_end", {31'd0, busy}, 32'd0);

      // en dropped during DATA bit 3 (symbol 12): byte completes, FIFO kept
      en = 1'b1;
      send_byte(8'h5A);
      wait_rise(n);
      in_dat = 8'h81;
      in_stb = 1'b1;
      @(negedge clk);
      in_dat = 8'h7E;
      @(negedge clk);
      in_stb = 1'b0;
      push_pre();
      push_byte(8'h5A);
      check_frame("en_drop", 2, 49, 1'b0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         if (tx_en !== 1'b0) hi++;
         @(negedge clk);
      end
      chk("en_drop_stays_idle", hi, 0);
      chk("en_drop_busy", {31'd0, busy}, 32'd1);
      en = 1'b1;
      @(negedge clk);
      wait_rise(n);
      chk("en_resume_latency", n, 0);
      push_pre();
      push_byte(8'h81);
      push_byte(8'h7E);
      check_frame("en_resume", 0, -1, 1'b0);
      chk("en_resume_busy_end", {31'd0, busy}, 32'd0);

      // async reset during DATA
      send_byte(8'hF0);
      wait_rise(n);
      in_dat = 8'h0F;
      in_stb = 1'b1;
      @(negedge clk);
      in_dat = 8'hAA;
      @(negedge clk);
      in_stb = 1'b0;
      for (int c = 2; c < 45; c++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tx_en", {31'd0, tx_en}, 32'd0);
      chk("arst_cw", {16'd0, control_word}, 32'h4000);
      chk("arst_pw", {16'd0, phase_word}, 32'h0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_full", {31'd0, fifo_full}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      hi = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_en !== 1'b0) hi++;
      end
      chk("arst_no_resume", hi, 0);
      chk("arst_busy_after", {31'd0, busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
